move_merge_engine: RTL and testbench

MOVE_MERGE_ENGINE -- requirements
Module: move_merge_engine

---
 rtl/move_merge_if.sv | 22 ++
 rtl/move_merge_engine.sv | 167 ++++++++++++++++
 tb/tb_move_merge_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/move_merge_if.sv
// Handshake and board bus between a move requester and the 2048 move/merge engine.
interface move_merge_if;
    logic                         start;
    logic [1:0]                   dir;
    logic [3:0][3:0][11:0]        board_in;
    logic [3:0][3:0][11:0]        board_out;
    logic                         moved;
    logic [15:0]                  score_delta;
    logic                         busy;
    logic                         done;
    logic                         win;

    modport master (
        output start, dir, board_in,
        input  board_out, moved, score_delta, busy, done, win
    );

    modport slave (
        input  start, dir, board_in,
        output board_out, moved, score_delta, busy, done, win
    );
endinterface

// File: rtl/move_merge_engine.sv
// 2048 move engine: slides and merges one lane per cycle toward the chosen wall.
// Optional macro MOVE_WIN_DETECT_EN builds the 2048-tile win flag; otherwise win is 0.
module move_merge_engine (
    input  logic         clk,
    input  logic         rst,
    move_merge_if.slave  bus
);
    localparam int unsigned TILE_W  = 12;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned N       = 4;
    localparam logic [TILE_W-1:0] MAX_TILE = TILE_W'(2048);

    typedef enum logic [1:0] {IDLE, LANE, FINISH} state_t;
    typedef logic [N-1:0][N-1:0][TILE_W-1:0] board_t;
    typedef logic [N-1:0][TILE_W-1:0]        lane_t;

    state_t               state;
    board_t               board_q;
    board_t               nxt_board;
    logic [1:0]           dir_q;
    logic [1:0]           lane_q;
    logic                 moved_q;
    logic [SCORE_W-1:0]   score_q;
    logic                 busy_q;
    logic                 done_q;
    lane_t                lane_in;
    lane_t                lane_out;
    logic [SCORE_W-1:0]   lane_pts;
    logic                 lane_moved;
    logic [3:0]           pos;
    logic [SCORE_W:0]     score_sum;

    // Board coordinate {row,col} of the j-th cell of lane k, j=0 nearest the wall.
    function automatic logic [3:0] cell_pos(input logic [1:0] d, input logic [1:0] k,
                                            input logic [1:0] j);
        case (d)
            2'd0:    return {j, k};
            2'd1:    return {2'(2'd3 - j), k};
            2'd2:    return {k, j};
            default: return {k, 2'(2'd3 - j)};
        endcase
    endfunction

    function automatic lane_t slide_lane(input lane_t v, output logic [SCORE_W-1:0] pts);
        logic [TILE_W-1:0] c [0:N];
        lane_t             o;
        logic [2:0]        cnt;
        logic [2:0]        k;
        logic              skip;
        for (int i = 0; i <= N; i++) c[i] = '0;
        o    = '0;
        cnt  = '0;
        k    = '0;
        skip = 1'b0;
        pts  = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i] != '0) begin
                c[cnt] = v[i];
                cnt    = cnt + 3'd1;
            end
        end
        // c[N] stays 0 so the last tile never finds a partner; 2048 pairs stay split.
        for (int i = 0; i < N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[i] != '0) begin
                if (c[i] == c[i+1] && c[i] != MAX_TILE) begin
                    o[k[1:0]] = {c[i][TILE_W-2:0], 1'b0};
                    pts       = pts + SCORE_W'({c[i][TILE_W-2:0], 1'b0});
                    skip      = 1'b1;
                end else begin
                    o[k[1:0]] = c[i];
                end
                k = k + 3'd1;
            end
        end
        return o;
    endfunction

    // Gather the current lane, resolve it, and scatter it back into a copy of the board.
    always_comb begin
        nxt_board = board_q;
        lane_in   = '0;
        pos       = '0;
        for (int j = 0; j < N; j++) begin
            pos        = cell_pos(dir_q, lane_q, 2'(j));
            lane_in[j] = board_q[pos[3:2]][pos[1:0]];
        end
        lane_out = slide_lane(lane_in, lane_pts);
        for (int j = 0; j < N; j++) begin
            pos = cell_pos(dir_q, lane_q, 2'(j));
            nxt_board[pos[3:2]][pos[1:0]] = lane_out[j];
        end
        lane_moved = (lane_out != lane_in);
        score_sum  = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(lane_pts);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            board_q <= '0;
            dir_q   <= '0;
            lane_q  <= '0;
            moved_q <= 1'b0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        board_q <= bus.board_in;
                        dir_q   <= bus.dir;
                        lane_q  <= '0;
                        moved_q <= 1'b0;
                        score_q <= '0;
                        busy_q  <= 1'b1;
                        state   <= LANE;
                    end
                end
                LANE: begin
                    board_q <= nxt_board;
                    moved_q <= moved_q | lane_moved;
                    score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    lane_q  <= lane_q + 2'd1;
                    if (lane_q == 2'd3) state <= FINISH;
                end
                FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOVE_WIN_DETECT_EN
    logic win_q;
    logic win_hit;

    always_comb begin
        win_hit = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (board_q[r][c] == MAX_TILE) win_hit = 1'b1;
    end

    // Win is captured alongside done and held until the next accepted move.
    always_ff @(posedge clk) begin
        if (rst)                            win_q <= 1'b0;
        else if (state == IDLE && bus.start) win_q <= 1'b0;
        else if (state == FINISH)           win_q <= win_hit;
    end

    assign bus.win = win_q;
`else
    assign bus.win = 1'b0;
`endif

    assign bus.board_out   = board_q;
    assign bus.moved       = moved_q;
    assign bus.score_delta = score_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_move_merge_engine.sv
// Directed, table-driven bench for move_merge_engine plus reset/busy corner sequences.
module tb_move_merge_engine;
    typedef logic [3:0][3:0][11:0] board_t;
    typedef struct {
        logic [1:0]  dir;
        board_t      bin;
        board_t      bexp;
        logic        mv;
        logic [15:0] sc;
    } vec_t;

`ifdef MOVE_WIN_DETECT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_merge_if bus();
    move_merge_engine dut (.clk(clk), .rst(rst), .bus(bus));

    vec_t vecs [9];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit has_max(input board_t b);
        bit hit = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 12'd2048) hit = 1'b1;
        return hit;
    endfunction

    task automatic run_vec(input int i, input string tag);
        int cyc = 0;
        bit seen = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dir      = vecs[i].dir;
        bus.board_in = vecs[i].bin;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.start    = 1'b0;
                bus.board_in = '1;
                chk({tag, "_busy"}, 192'(bus.busy), 192'(1));
            end
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 192'(cyc), 192'(6));
        chk({tag, "_board"}, 192'(bus.board_out), 192'(vecs[i].bexp));
        chk({tag, "_moved"}, 192'(bus.moved), 192'(vecs[i].mv));
        chk({tag, "_score"}, 192'(bus.score_delta), 192'(vecs[i].sc));
        chk({tag, "_win"}, 192'(bus.win), 192'(WIN_EN && has_max(vecs[i].bexp)));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 192'(bus.done), 192'(0));
        chk({tag, "_idle"}, 192'(bus.busy), 192'(0));
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, 192'(bus.board_out), 192'(vecs[i].bexp));
        chk({tag, "_hold_score"}, 192'(bus.score_delta), 192'(vecs[i].sc));
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 9; i++) begin
            vecs[i].bin  = '0;
            vecs[i].bexp = '0;
            vecs[i].mv   = 1'b1;
        end
        // row0 [2,2,2,2] left
        vecs[0].dir = 2'd2;
        for (int c = 0; c < 4; c++) vecs[0].bin[0][c] = 12'd2;
        vecs[0].bexp[0][0] = 12'd4; vecs[0].bexp[0][1] = 12'd4; vecs[0].sc = 16'd8;
        // col0 rows [2,0,2,4] down
        vecs[1].dir = 2'd1;
        vecs[1].bin[0][0] = 12'd2; vecs[1].bin[2][0] = 12'd2; vecs[1].bin[3][0] = 12'd4;
        vecs[1].bexp[2][0] = 12'd4; vecs[1].bexp[3][0] = 12'd4; vecs[1].sc = 16'd4;
        // row1 [4,8,16,32] left: nothing moves
        vecs[2].dir = 2'd2;
        vecs[2].bin[1][0] = 12'd4; vecs[2].bin[1][1] = 12'd8;
        vecs[2].bin[1][2] = 12'd16; vecs[2].bin[1][3] = 12'd32;
        vecs[2].bexp = vecs[2].bin; vecs[2].mv = 1'b0; vecs[2].sc = 16'd0;
        // row2 [0,2048,0,2048] right: no merge of 2048s
        vecs[3].dir = 2'd3;
        vecs[3].bin[2][1] = 12'd2048; vecs[3].bin[2][3] = 12'd2048;
        vecs[3].bexp[2][2] = 12'd2048; vecs[3].bexp[2][3] = 12'd2048; vecs[3].sc = 16'd0;
        // col1 rows [2,2,4,4] up
        vecs[4].dir = 2'd0;
        vecs[4].bin[0][1] = 12'd2; vecs[4].bin[1][1] = 12'd2;
        vecs[4].bin[2][1] = 12'd4; vecs[4].bin[3][1] = 12'd4;
        vecs[4].bexp[0][1] = 12'd4; vecs[4].bexp[1][1] = 12'd8; vecs[4].sc = 16'd12;
        // row3 [2,2,2,0] right: wall-side pair merges first
        vecs[5].dir = 2'd3;
        vecs[5].bin[3][0] = 12'd2; vecs[5].bin[3][1] = 12'd2; vecs[5].bin[3][2] = 12'd2;
        vecs[5].bexp[3][2] = 12'd2; vecs[5].bexp[3][3] = 12'd4; vecs[5].sc = 16'd4;
        // row0 [4,4,8,0], row1 [0,0,0,2] left: merged tile not re-merged
        vecs[6].dir = 2'd2;
        vecs[6].bin[0][0] = 12'd4; vecs[6].bin[0][1] = 12'd4; vecs[6].bin[0][2] = 12'd8;
        vecs[6].bin[1][3] = 12'd2;
        vecs[6].bexp[0][0] = 12'd8; vecs[6].bexp[0][1] = 12'd8; vecs[6].bexp[1][0] = 12'd2;
        vecs[6].sc = 16'd8;
        // row0 [0,0,1024,1024] left: creates 2048
        vecs[7].dir = 2'd2;
        vecs[7].bin[0][2] = 12'd1024; vecs[7].bin[0][3] = 12'd1024;
        vecs[7].bexp[0][0] = 12'd2048; vecs[7].sc = 16'd2048;
        // full board of 2s down
        vecs[8].dir = 2'd1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                vecs[8].bin[r][c] = 12'd2;
                if (r >= 2) vecs[8].bexp[r][c] = 12'd4;
            end
        vecs[8].sc = 16'd32;

        rst = 1'b1; bus.start = 1'b0; bus.dir = 2'd0; bus.board_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_board", 192'(bus.board_out), 192'(0));
        chk("rst_flags", 192'({bus.moved, bus.busy, bus.done, bus.win}), 192'(0));
        chk("rst_score", 192'(bus.score_delta), 192'(0));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, $sformatf("vec%0d", i));

        // Reset two cycles into a move aborts it.
        @(negedge clk);
        bus.start = 1'b1; bus.dir = vecs[0].dir; bus.board_in = vecs[0].bin;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", 192'(dones), 192'(0));
        chk("abort_board", 192'(bus.board_out), 192'(0));
        chk("abort_busy", 192'(bus.busy), 192'(0));
        chk("abort_score", 192'(bus.score_delta), 192'(0));
        run_vec(0, "after_abort");

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.dir = vecs[0].dir; bus.board_in = vecs[0].bin;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 192'(bus.busy), 192'(0));
        chk("rst_prio_board", 192'(bus.board_out), 192'(0));

        // Second start while busy is dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.dir = vecs[1].dir; bus.board_in = vecs[1].bin;
        dones = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 2) begin
                bus.start = 1'b1; bus.dir = vecs[2].dir; bus.board_in = vecs[2].bin;
            end
            if (c == 3) bus.start = 1'b0;
            if (bus.done) dones++;
        end
        chk("busy_one_done", 192'(dones), 192'(1));
        chk("busy_board", 192'(bus.board_out), 192'(vecs[1].bexp));
        chk("busy_score", 192'(bus.score_delta), 192'(vecs[1].sc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
